// File: rtl/timer_pkg.sv
// Shared definitions for the Wishbone timer bank:
// register offsets, CTRL bit indices, bus FSM states.
package timer_pkg;

  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_PRESC = 4'h4;
  localparam logic [3:0] OFF_CMP   = 4'h8;
  localparam logic [3:0] OFF_COUNT = 4'hc;

  localparam logic [15:0] OFF_STATUS = 16'h0100;
  localparam logic [15:0] OFF_CYCLES = 16'h0104;
  localparam logic [15:0] CH_STRIDE  = 16'h0010;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IE  = 2;

  typedef enum logic {
    IDLE,
    ACK
  } bus_state_e;

  function automatic logic [31:0] merge32(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  sel
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = {8{sel[i]}};
    return (old & ~m) | (wd & m);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up-counter and compare,
// with a one-cycle strobe when the compare match fires.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_ctrl,
  input  logic               we_presc,
  input  logic               we_cmp,
  input  logic               we_count,
  input  logic [31:0]        wdat,
  input  logic [3:0]         wsel,
  output logic [2:0]         ctrl,
  output logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   cmp,
  output logic [CNT_W-1:0]   count,
  output logic               hit
);

  logic [PRESC_W-1:0] pcnt;
  logic [2:0]         ctrl_w;
  logic               en;
  logic               tick;

  assign en     = ctrl[CTRL_EN];
  assign tick   = en && (pcnt == presc);
  assign hit    = tick && (count == cmp);
  assign ctrl_w = 3'(merge32(32'(ctrl), wdat, wsel));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl  <= '0;
      presc <= '0;
      cmp   <= '0;
      count <= '0;
      pcnt  <= '0;
    end else begin
      if (we_ctrl)
        ctrl <= ctrl_w;
      else if (hit && !ctrl[CTRL_PER])
        ctrl[CTRL_EN] <= 1'b0;

      // a fresh enable restarts the prescale period
      if (we_ctrl && !en && ctrl_w[CTRL_EN])
        pcnt <= '0;
      else if (tick)
        pcnt <= '0;
      else if (en)
        pcnt <= pcnt + PRESC_W'(1);

      if (we_presc)
        presc <= PRESC_W'(
          merge32(32'(presc), wdat, wsel));

      if (we_cmp)
        cmp <= CNT_W'(
          merge32(32'(cmp), wdat, wsel));

      if (we_count)
        count <= CNT_W'(
          merge32(32'(count), wdat, wsel));
      else if (hit) begin
        if (ctrl[CTRL_PER])
          count <= '0;
      end else if (tick)
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_timer_bank.sv
// Wishbone timer bank: NUM_CH timer channels, W1C pending
// status, free-running cycle counter and interrupt outputs.
module wb_timer_bank
  import timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          PRESC_W   = 16,
  parameter logic [15:0] BASE_ADDR = 16'he000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic [NUM_CH-1:0] ch_irq_o,
  output logic              irq_o
);

  bus_state_e state;
  bus_state_e state_nxt;

  logic        req;
  logic        wr;
  logic [15:0] off;
  logic [3:0]  ch_idx;
  logic [3:0]  reg_off;
  logic        ch_ok;
  logic        is_status;
  logic        is_cycles;
  logic [31:0] rdata;
  logic        unused_bits;

  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] st_clr;
  logic [NUM_CH-1:0] ie_vec;
  logic [NUM_CH-1:0] ch_hit;
  logic [31:0]       cycles;

  logic [2:0]         ch_ctrl  [NUM_CH];
  logic [PRESC_W-1:0] ch_presc [NUM_CH];
  logic [CNT_W-1:0]   ch_cmp   [NUM_CH];
  logic [CNT_W-1:0]   ch_count [NUM_CH];

  assign off       = wb_adr_i[15:0] - BASE_ADDR;
  assign ch_idx    = off[7:4];
  assign reg_off   = {off[3:2], 2'b00};
  assign ch_ok     = (off[15:8] == 8'h00)
                  && (int'(ch_idx) < NUM_CH);
  assign is_status = off[15:2] == OFF_STATUS[15:2];
  assign is_cycles = off[15:2] == OFF_CYCLES[15:2];

  assign unused_bits = ^{wb_adr_i[31:16], off[1:0]};

  assign req = wb_cyc_i & wb_stb_i & (state == IDLE);
  assign wr  = req & wb_we_i;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic sel_ch;
    assign sel_ch = wr && ch_ok && (ch_idx == 4'(n));
    assign ie_vec[n] = ch_ctrl[n][CTRL_IE];

    timer_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_i),
      .we_ctrl  (sel_ch && reg_off == OFF_CTRL),
      .we_presc (sel_ch && reg_off == OFF_PRESC),
      .we_cmp   (sel_ch && reg_off == OFF_CMP),
      .we_count (sel_ch && reg_off == OFF_COUNT),
      .wdat     (wb_dat_i),
      .wsel     (wb_sel_i),
      .ctrl     (ch_ctrl[n]),
      .presc    (ch_presc[n]),
      .cmp      (ch_cmp[n]),
      .count    (ch_count[n]),
      .hit      (ch_hit[n])
    );
  end

  always_comb begin
    rdata = '0;
    if (is_status)
      rdata = 32'(status);
    else if (is_cycles)
      rdata = cycles;
    else if (ch_ok) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_idx == 4'(n)) begin
          case (reg_off)
            OFF_CTRL:  rdata = 32'(ch_ctrl[n]);
            OFF_PRESC: rdata = 32'(ch_presc[n]);
            OFF_CMP:   rdata = 32'(ch_cmp[n]);
            OFF_COUNT: rdata = 32'(ch_count[n]);
            default:   rdata = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    st_clr = '0;
    if (wr && is_status)
      st_clr = NUM_CH'(
        merge32(32'h0, wb_dat_i, wb_sel_i));
  end

  // hardware set beats a same-edge W1C
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      status   <= '0;
      ch_irq_o <= '0;
      cycles   <= '0;
    end else begin
      status   <= (status & ~st_clr) | ch_hit;
      ch_irq_o <= status & ie_vec;
      if (wr && is_cycles)
        cycles <= merge32(cycles, wb_dat_i, wb_sel_i);
      else
        cycles <= cycles + 32'd1;
    end
  end

  assign irq_o = |ch_irq_o;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = ACK;
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_ack_o = (state == ACK);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i)
      wb_dat_o <= '0;
    else if (req)
      wb_dat_o <= rdata;
  end

endmodule
